tt_um_carlosgs99_div_8by4: RTL and testbench

//  Sequential shift/subtract (restoring) unsigned divider: 2*BITS-bit dividend / BITS-bit divisor.

---
 rtl/tt_um_carlosgs99_div_8by4.sv | 173 +++++++++++++++++
 tb/tb_tt_um_carlosgs99_div_8by4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tt_um_carlosgs99_div_8by4.sv
// Sequential restoring divider: 2*BITS-bit dividend / BITS-bit divisor.
// One quotient bit per enabled clock, start/busy/done handshake, results held
// until the next completion. ena=0 freezes every register.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor bypasses RUN and raises io_dz.
//
// state  | meaning
// IDLE   | waiting for io_start
// RUN    | shifting/subtracting, one quotient bit per enabled cycle
// DONE   | result valid, io_done high; io_start here starts the next operation

module tt_um_carlosgs99_div_8by4 #(
    parameter int BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                io_start,
    input  logic [2*BITS-1:0]   io_dividend,
    input  logic [BITS-1:0]     io_divisor,
    output logic [2*BITS-1:0]   io_quotient,
    output logic [BITS-1:0]     io_remainder,
    output logic                io_busy,
    output logic                io_done,
    output logic                io_dz
);

    localparam int DW    = 2 * BITS;
    localparam int CNT_W = $clog2(DW);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DW - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0]    dvd;
    logic [BITS-1:0]  dvs;
    logic [BITS-1:0]  rem;
    logic [DW-1:0]    q;
    logic [CNT_W-1:0] cnt;
    logic [DW-1:0]    quo_r;
    logic [BITS-1:0]  rem_r;

    logic             accept;
    logic             start_zero;
    logic [BITS:0]    rw;
    logic             step_ge;
    logic [BITS-1:0]  rem_step;
    logic [DW-1:0]    q_step;

    assign accept = ena && io_start && (state == S_IDLE || state == S_DONE);

`ifdef DIV_ZERO_DETECT_EN
    assign start_zero = (io_divisor == '0);
`else
    assign start_zero = 1'b0;
`endif

    // One restoring step: bring down the next dividend bit, subtract if it fits
    always_comb begin
        rw       = {rem, dvd[DW-1]};
        step_ge  = (rw >= {1'b0, dvs});
        rem_step = rw[BITS-1:0];
        if (step_ge) begin
            rem_step = BITS'(rw - {1'b0, dvs});
        end
        q_step = {q[DW-2:0], step_ge};
    end

    // State register, frozen while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (io_start) begin
                    state_nxt = start_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (io_start) begin
                    state_nxt = start_zero ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        io_busy = 1'b0;
        io_done = 1'b0;
        case (state)
            S_RUN:   io_busy = 1'b1;
            S_DONE:  io_done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, shift/subtract datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd   <= '0;
            dvs   <= '0;
            rem   <= '0;
            q     <= '0;
            cnt   <= '0;
            quo_r <= '0;
            rem_r <= '0;
        end else if (ena) begin
            if (accept) begin
                dvd <= io_dividend;
                dvs <= io_divisor;
                rem <= '0;
                q   <= '0;
                cnt <= '0;
                // Zero-divisor bypass reproduces what the full algorithm would give
                if (start_zero) begin
                    quo_r <= '1;
                    rem_r <= io_dividend[BITS-1:0];
                end
            end else if (state == S_RUN) begin
                dvd <= dvd << 1;
                rem <= rem_step;
                q   <= q_step;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_LAST) begin
                    quo_r <= q_step;
                    rem_r <= rem_step;
                end
            end
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dz_r;

    // Divide-by-zero flag: set by a zero-divisor start, cleared by any other start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_r <= 1'b0;
        end else if (accept) begin
            dz_r <= start_zero;
        end
    end

    assign io_dz = dz_r;
`else
    assign io_dz = 1'b0;
`endif

    assign io_quotient  = quo_r;
    assign io_remainder = rem_r;

endmodule

// File: tb/tb_tt_um_carlosgs99_div_8by4.sv
// Directed bench for the 8-by-4 restoring divider (default build, no zero detect).
module tb_tt_um_carlosgs99_div_8by4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       io_start;
    logic [7:0] io_dividend;
    logic [3:0] io_divisor;
    logic [7:0] io_quotient;
    logic [3:0] io_remainder;
    logic       io_busy;
    logic       io_done;
    logic       io_dz;

    int total = 0;
    int bad   = 0;
    int n;
    int seen_done;

    tt_um_carlosgs99_div_8by4 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .io_start     (io_start),
        .io_dividend  (io_dividend),
        .io_divisor   (io_divisor),
        .io_quotient  (io_quotient),
        .io_remainder (io_remainder),
        .io_busy      (io_busy),
        .io_done      (io_done),
        .io_dz        (io_dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // Counts enabled edges until io_done is seen, bounded at 40
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!io_done && cycles < 40) begin
            step(1);
            cycles++;
        end
    endtask

    // Presents one start for a single edge, then checks latency and result
    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er);
        int lat;
        io_dividend = a;
        io_divisor  = b;
        io_start    = 1'b1;
        step(1);
        io_start = 1'b0;
        check({tag, "_busy"}, io_busy, 1);
        wait_done(lat);
        check({tag, "_lat"}, lat, 8);
        check({tag, "_q"}, io_quotient, eq);
        check({tag, "_r"}, io_remainder, er);
        check({tag, "_dz"}, io_dz, 0);
        step(1);
        check({tag, "_done_drop"}, io_done, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        io_start    = 1'b0;
        io_dividend = 8'd0;
        io_divisor  = 4'd0;
        #2;
        check("reset_q", io_quotient, 0);
        check("reset_r", io_remainder, 0);
        check("reset_flags", {io_busy, io_done, io_dz}, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        check("idle_flags", {io_busy, io_done}, 0);

        run_div("d200_7", 8'd200, 4'd7, 8'd28, 4'd4);
        run_div("d255_1", 8'd255, 4'd1, 8'd255, 4'd0);
        run_div("d0_15", 8'd0, 4'd15, 8'd0, 4'd0);
        run_div("d14_15", 8'd14, 4'd15, 8'd0, 4'd14);
        run_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0);

        // Back-to-back: start held high straight through the DONE cycle
        io_dividend = 8'd100;
        io_divisor  = 4'd10;
        io_start    = 1'b1;
        step(1);
        io_dividend = 8'd99;
        io_divisor  = 4'd9;
        wait_done(n);
        check("b2b_lat1", n, 8);
        check("b2b_q1", io_quotient, 10);
        check("b2b_r1", io_remainder, 0);
        step(1);
        io_start = 1'b0;
        check("b2b_rerun", {io_busy, io_done}, 2'b10);
        wait_done(n);
        check("b2b_gap", n + 1, 9);
        check("b2b_q2", io_quotient, 11);
        check("b2b_r2", io_remainder, 0);
        step(1);

        // Mid-RUN: start/operand changes ignored, ena low stretches by 3 cycles
        io_dividend = 8'd200;
        io_divisor  = 4'd7;
        io_start    = 1'b1;
        step(1);
        io_start = 1'b0;
        step(2);
        io_start    = 1'b1;
        io_dividend = 8'd3;
        io_divisor  = 4'd1;
        step(2);
        io_start = 1'b0;
        ena      = 1'b0;
        step(3);
        check("ena_freeze", {io_busy, io_done}, 2'b10);
        ena = 1'b1;
        wait_done(n);
        check("ena_lat", n, 4);
        check("mid_q", io_quotient, 28);
        check("mid_r", io_remainder, 4);
        ena = 1'b0;
        step(2);
        check("done_held", io_done, 1);
        ena = 1'b1;
        step(1);
        check("done_release", io_done, 0);

        // Asynchronous reset during RUN aborts with no done pulse
        io_dividend = 8'd255;
        io_divisor  = 4'd1;
        io_start    = 1'b1;
        step(1);
        io_start = 1'b0;
        step(3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", io_quotient, 0);
        check("arst_r", io_remainder, 0);
        check("arst_flags", {io_busy, io_done, io_dz}, 0);
        #3;
        rst_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (io_done) seen_done = 1;
        end
        check("arst_no_done", seen_done, 0);
        run_div("d50_5", 8'd50, 4'd5, 8'd10, 4'd0);

        // Zero divisor runs the full length in the default build
        run_div("dz_a7", 8'hA7, 4'd0, 8'hFF, 4'h7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
